// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot pixel solver.
// Fixed point is signed 4.23 in 27 bits; magnitudes use a 28-bit format.
package mandelbrot_pkg;

    localparam int FX_W    = 27;
    localparam int FX_FRAC = 23;

    typedef logic signed [FX_W-1:0] fx_t;

    // 4.0 in 4.23 format, widened by one bit to match the |z|^2 sum
    localparam logic signed [FX_W:0] ESCAPE_SQ = 28'sh2000000;

    typedef enum logic [2:0] {IDLE, INIT, ITER, WRITE, DONE} state_t;

    // 3-3-2 RGB palette entries
    localparam logic [7:0] PAL_IN_SET = 8'h00;
    localparam logic [7:0] PAL_HIGH   = 8'hE0;
    localparam logic [7:0] PAL_MID    = 8'hFC;
    localparam logic [7:0] PAL_LOW    = 8'h1C;
    localparam logic [7:0] PAL_FAST   = 8'h03;

    // Maps an escape count onto the palette, banded by fractions of the cap
    function automatic logic [7:0] palette_colour(input int unsigned cnt,
                                                  input int unsigned max_it);
        if (cnt >= max_it)           return PAL_IN_SET;
        else if (cnt >= max_it / 2)  return PAL_HIGH;
        else if (cnt >= max_it / 4)  return PAL_MID;
        else if (cnt >= max_it / 8)  return PAL_LOW;
        else                         return PAL_FAST;
    endfunction

endpackage

// File: rtl/mandelbrot_pixel_solver_fx_mul.sv
// fx_mul: combinational signed 4.23 x 4.23 multiply, truncated back to 4.23.
// ovf flags a product whose integer part does not fit the 4.23 result.
module fx_mul
    import mandelbrot_pkg::*;
(
    input  logic signed [26:0] a,
    input  logic signed [26:0] b,
    output logic signed [26:0] p,
    output logic               ovf
);

    logic signed [2*FX_W-1:0] prod;

    // Full-width product; the result keeps bits [49:23]
    always_comb begin
        prod = (2*FX_W)'(a) * (2*FX_W)'(b);
        p    = fx_t'(prod >>> FX_FRAC);
        ovf  = (prod[2*FX_W-1:FX_W+FX_FRAC-1] != '0) &&
               (prod[2*FX_W-1:FX_W+FX_FRAC-1] != '1);
    end

endmodule

// File: rtl/mandelbrot_pixel_solver.sv
// mandelbrot_pixel_solver: sweeps one display partition in raster order,
// iterating z = z^2 + c per pixel and writing one colour byte per pixel.
// Optional macro MANDELBROT_COLOR_MAP_EN selects the 3-3-2 palette;
// otherwise the raw iteration count is written (0 for in-set pixels).
module mandelbrot_pixel_solver
    import mandelbrot_pkg::*;
#(
    parameter int MAX_ITERATIONS     = 100,
    parameter int PARTITION_ROW_SIZE = 320,
    parameter int PARTITION_COL_SIZE = 480,
    parameter int ADDR_W = (PARTITION_ROW_SIZE * PARTITION_COL_SIZE > 1) ?
                           $clog2(PARTITION_ROW_SIZE * PARTITION_COL_SIZE) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [26:0]       init_x,
    input  logic signed [26:0]       init_y,
    input  logic signed [26:0]       x_incr,
    input  logic signed [26:0]       y_incr,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [7:0]               wr_data,
    output logic                     busy,
    output logic                     done
);

    localparam int CNT_W = $clog2(MAX_ITERATIONS + 1);
    localparam int COL_W = (PARTITION_ROW_SIZE > 1) ? $clog2(PARTITION_ROW_SIZE) : 1;
    localparam int ROW_W = (PARTITION_COL_SIZE > 1) ? $clog2(PARTITION_COL_SIZE) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_ITERATIONS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(PARTITION_ROW_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PARTITION_COL_SIZE - 1);

    state_t            state;
    fx_t               cr, ci, zx, zy;
    logic [CNT_W-1:0]  cnt;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        colour_q;

    fx_t               zx2, zy2, zxzy;
    logic              zx2_ovf, zy2_ovf, zxzy_ovf;
    logic signed [FX_W:0] mag;
    logic              escape;
    logic [7:0]        colour_next;

    fx_mul u_mul_xx (.a(zx), .b(zx), .p(zx2),  .ovf(zx2_ovf));
    fx_mul u_mul_yy (.a(zy), .b(zy), .p(zy2),  .ovf(zy2_ovf));
    fx_mul u_mul_xy (.a(zx), .b(zy), .p(zxzy), .ovf(zxzy_ovf));

    // Escape test on the current z and colour of the current count.
    // A product that overflows 4.23 already means |z|^2 > 4, so it counts as escape.
    always_comb begin
        mag    = (FX_W+1)'(zx2) + (FX_W+1)'(zy2);
        escape = zx2_ovf || zy2_ovf || zxzy_ovf || (mag > ESCAPE_SQ);
`ifdef MANDELBROT_COLOR_MAP_EN
        colour_next = palette_colour(32'(cnt), MAX_ITERATIONS);
`else
        colour_next = (cnt >= CNT_MAX) ? PAL_IN_SET : 8'(cnt);
`endif
    end

    // Sweep FSM with registered write port and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cr       <= '0;
            ci       <= '0;
            zx       <= '0;
            zy       <= '0;
            cnt      <= '0;
            col      <= '0;
            row      <= '0;
            addr     <= '0;
            colour_q <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        cr    <= init_x;
                        ci    <= init_y;
                        col   <= '0;
                        row   <= '0;
                        addr  <= '0;
                        state <= INIT;
                    end
                end
                INIT: begin
                    busy  <= 1'b1;
                    zx    <= '0;
                    zy    <= '0;
                    cnt   <= '0;
                    state <= ITER;
                end
                ITER: begin
                    busy <= 1'b1;
                    if (escape || cnt == CNT_MAX) begin
                        colour_q <= colour_next;
                        state    <= WRITE;
                    end else begin
                        zx  <= zx2 - zy2 + cr;
                        zy  <= (zxzy <<< 1) + ci;
                        cnt <= cnt + 1'b1;
                    end
                end
                WRITE: begin
                    busy    <= 1'b1;
                    wr_en   <= 1'b1;
                    wr_addr <= addr;
                    wr_data <= colour_q;
                    // Position only advances while pixels remain, so addr never wraps
                    if (row == ROW_LAST && col == COL_LAST) begin
                        state <= DONE;
                    end else begin
                        addr <= addr + 1'b1;
                        if (col != COL_LAST) begin
                            col <= col + 1'b1;
                            cr  <= cr + x_incr;
                        end else begin
                            col <= '0;
                            cr  <= init_x;
                            row <= row + 1'b1;
                            ci  <= ci + y_incr;
                        end
                        state <= INIT;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                    if (start) begin
                        done  <= 1'b0;
                        cr    <= init_x;
                        ci    <= init_y;
                        col   <= '0;
                        row   <= '0;
                        addr  <= '0;
                        state <= INIT;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_pixel_solver.sv
// Directed scoreboard bench for mandelbrot_pixel_solver: a 1x1 instance for
// single-pixel escape behaviour and a 4x2 instance for sweeps, reset and restart.
module tb_mandelbrot_pixel_solver;
    import mandelbrot_pkg::*;

    localparam int MAXI = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset   = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic signed [26:0] init_x = '0, init_y = '0, x_incr = '0, y_incr = '0;

    logic       a_wr_en, a_busy, a_done;
    logic [0:0] a_wr_addr;
    logic [7:0] a_wr_data;
    logic       b_wr_en, b_busy, b_done;
    logic [2:0] b_wr_addr;
    logic [7:0] b_wr_data;

    mandelbrot_pixel_solver #(
        .MAX_ITERATIONS(MAXI), .PARTITION_ROW_SIZE(1), .PARTITION_COL_SIZE(1)
    ) u_a (
        .clk(clk), .reset(reset), .start(start_a),
        .init_x(init_x), .init_y(init_y), .x_incr(x_incr), .y_incr(y_incr),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .busy(a_busy), .done(a_done)
    );

    mandelbrot_pixel_solver #(
        .MAX_ITERATIONS(MAXI), .PARTITION_ROW_SIZE(4), .PARTITION_COL_SIZE(2)
    ) u_b (
        .clk(clk), .reset(reset), .start(start_b),
        .init_x(init_x), .init_y(init_y), .x_incr(x_incr), .y_incr(y_incr),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .busy(b_busy), .done(b_done)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   wr_count = 0;
    int   last_wr_cyc = 0;
    logic sel_b = 1'b0;

    // Escape counts worked out by hand for the 4x2 grid, raster order
    int unsigned b_cnts[8] = '{3, 4, 100, 2, 5, 100, 100, 5};

    function automatic logic [31:0] colour_of(input int unsigned cnt);
`ifdef MANDELBROT_COLOR_MAP_EN
        if (cnt >= MAXI)           return 32'h00;
        else if (cnt >= MAXI / 2)  return 32'hE0;
        else if (cnt >= MAXI / 4)  return 32'hFC;
        else if (cnt >= MAXI / 8)  return 32'h1C;
        else                       return 32'h03;
`else
        return (cnt >= MAXI) ? 32'h00 : 32'(cnt & 8'hFF);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; samples the selected instance on the falling edge and scores writes
    task automatic tick();
        logic        wr;
        logic [31:0] obs_addr, obs_data;
        exp_t        e;
        @(negedge clk);
        cyc++;
        wr       = sel_b ? b_wr_en : a_wr_en;
        obs_addr = sel_b ? 32'(b_wr_addr) : 32'(a_wr_addr);
        obs_data = sel_b ? 32'(b_wr_data) : 32'(a_wr_data);
        if (wr === 1'b1) begin
            wr_count++;
            last_wr_cyc = cyc;
            if (sb.size() == 0) begin
                check("write_was_expected", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("wr_addr", obs_addr, e.addr);
                check("wr_data", obs_data, e.data);
            end
        end
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((sel_b ? b_done : a_done) === 1'b1) break;
            tick();
        end
        check("done_reached", 32'(sel_b ? b_done : a_done), 32'd1);
    endtask

    task automatic run_1x1(input string tag, input logic signed [26:0] cx, input int unsigned cnt);
        sel_b  = 1'b0;
        init_x = cx;
        init_y = '0;
        x_incr = '0;
        y_incr = '0;
        sb.push_back('{32'd0, colour_of(cnt)});
        wr_count = 0;
        cyc = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 400 && wr_count == 0; i++) tick();
        check({tag, "_latency"}, 32'(last_wr_cyc), 32'(cnt + 4));
        tick();
        check({tag, "_done"}, 32'(a_done), 32'd1);
        check({tag, "_busy"}, 32'(a_busy), 32'd0);
        check({tag, "_writes"}, 32'(wr_count), 32'd1);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic push_sweep();
        for (int i = 0; i < 8; i++) sb.push_back('{32'(i), colour_of(b_cnts[i])});
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_a_wr_en", 32'(a_wr_en), 32'd0);
        check("rst_a_busy", 32'(a_busy), 32'd0);
        check("rst_a_done", 32'(a_done), 32'd0);
        check("rst_b_wr_addr", 32'(b_wr_addr), 32'd0);
        check("rst_b_wr_data", 32'(b_wr_data), 32'd0);
        check("rst_b_state", 32'(u_b.state), 32'(IDLE));
        reset = 1'b0;
        tick();

        // Single-pixel escape behaviour
        run_1x1("c_zero", 27'h0000000, 100);
        run_1x1("c_one", 27'h0800000, 3);
        run_1x1("c_minus_two", 27'h7000000, 100);

        // 4x2 sweep from (-1, 1), steps +0.5 / -0.5
        sel_b  = 1'b1;
        init_x = 27'h7800000;
        init_y = 27'h0800000;
        x_incr = 27'h0400000;
        y_incr = 27'h7C00000;

        // Reset mid-sweep at cycle 40
        push_sweep();
        wr_count = 0;
        cyc = 0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        while (cyc < 40) tick();
        check("pre_reset_writes", 32'(wr_count), 32'd2);
        reset = 1'b1;
        tick();
        check("midrst_wr_en", 32'(b_wr_en), 32'd0);
        check("midrst_busy", 32'(b_busy), 32'd0);
        check("midrst_done", 32'(b_done), 32'd0);
        check("midrst_state", 32'(u_b.state), 32'(IDLE));
        reset = 1'b0;
        sb.delete();
        wr_count = 0;
        for (int i = 0; i < 200; i++) tick();
        check("post_reset_no_writes", 32'(wr_count), 32'd0);
        check("post_reset_state", 32'(u_b.state), 32'(IDLE));

        // Full sweep with a start pulse landing in ITER
        push_sweep();
        wr_count = 0;
        cyc = 0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        while (cyc < 20) tick();
        check("start_in_iter_state", 32'(u_b.state), 32'(ITER));
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_done(2000);
        check("sweep_writes", 32'(wr_count), 32'd8);
        check("sweep_done_after_last", 32'(cyc - last_wr_cyc), 32'd1);
        check("sweep_busy", 32'(b_busy), 32'd0);
        check("sweep_sb_empty", 32'(sb.size()), 32'd0);

        // Restart from DONE
        push_sweep();
        wr_count = 0;
        cyc = 0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("restart_done_clear", 32'(b_done), 32'd0);
        wait_done(2000);
        check("restart_writes", 32'(wr_count), 32'd8);
        check("restart_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
